// File: rtl/out_sa_row_deskew.sv
// Row de-skew buffer: one FIFO per systolic-array row, released as aligned vectors over valid/ready.
// Optional sticky drop detection is built when OUT_SA_DESKEW_OVF_EN is defined.
module out_sa_row_deskew #(
    parameter int ROW    = 8,
    parameter int W_DATA = 8,
    parameter int DEPTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ROW*(W_DATA+1)-1:0] i_data,
    output logic [ROW*W_DATA-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = W_DATA + 1;

    logic [W_DATA-1:0] mem_r    [ROW][DEPTH];
    logic [AW-1:0]     wr_ptr_r [ROW];
    logic [AW-1:0]     rd_ptr_r [ROW];
    logic [CW-1:0]     count_r  [ROW];
    logic [AW-1:0]     wr_ptr_s [ROW];
    logic [AW-1:0]     rd_ptr_s [ROW];
    logic [CW-1:0]     count_s  [ROW];
    logic [CW-1:0]     remain_s [ROW];
    logic [W_DATA-1:0] wdata_s  [ROW];
    logic [W_DATA-1:0] head_s   [ROW];
    logic [ROW-1:0]    tag_s;
    logic [ROW-1:0]    full_s;
    logic [ROW-1:0]    push_s;
    logic              pop_s;
    logic              all_valid_s;
    logic [ROW*W_DATA-1:0] data_s;
    logic              o_valid_r;
    logic [ROW*W_DATA-1:0] o_data_r;
    logic [CW-1:0]     o_level_r;

    // Next-state of every row FIFO plus the head each row will present after this edge.
    always_comb begin
        pop_s       = o_valid_r & i_ready;
        all_valid_s = 1'b1;
        data_s      = '0;
        for (int i = 0; i < ROW; i++) begin
            tag_s[i]   = i_data[LW*(ROW-i)-1];
            wdata_s[i] = i_data[LW*(ROW-i)-2 -: W_DATA];
            full_s[i]  = (count_r[i] == CW'(DEPTH));
            push_s[i]  = tag_s[i] & (~full_s[i] | pop_s);
            case ({push_s[i], pop_s})
                2'b10:   count_s[i] = count_r[i] + CW'(1);
                2'b01:   count_s[i] = count_r[i] - CW'(1);
                default: count_s[i] = count_r[i];
            endcase
            remain_s[i] = pop_s ? (count_r[i] - CW'(1)) : count_r[i];
            rd_ptr_s[i] = pop_s ? (rd_ptr_r[i] + AW'(1)) : rd_ptr_r[i];
            wr_ptr_s[i] = push_s[i] ? (wr_ptr_r[i] + AW'(1)) : wr_ptr_r[i];
            // When nothing old survives the pop, the head is the word being written now.
            if (count_s[i] == CW'(0)) begin
                head_s[i] = '0;
            end else if (remain_s[i] == CW'(0)) begin
                head_s[i] = wdata_s[i];
            end else begin
                head_s[i] = mem_r[i][rd_ptr_s[i]];
            end
            if (count_s[i] == CW'(0)) begin
                all_valid_s = 1'b0;
            end else begin
                all_valid_s = all_valid_s;
            end
        end
        for (int i = 0; i < ROW; i++) begin
            data_s[W_DATA*(ROW-i)-1 -: W_DATA] = all_valid_s ? head_s[i] : '0;
        end
    end

    // FIFO storage writes; pointers being cleared makes old contents unreachable after reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < ROW; i++) begin
            if (!i_rst && push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= wdata_s[i];
            end
        end
    end

    // Pointers, counts and the registered output view.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ROW; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
            o_valid_r <= 1'b0;
            o_data_r  <= '0;
            o_level_r <= '0;
        end else begin
            for (int i = 0; i < ROW; i++) begin
                wr_ptr_r[i] <= wr_ptr_s[i];
                rd_ptr_r[i] <= rd_ptr_s[i];
                count_r[i]  <= count_s[i];
            end
            o_valid_r <= all_valid_s;
            o_data_r  <= data_s;
            o_level_r <= count_s[0];
        end
    end

    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_level = o_level_r;

`ifdef OUT_SA_DESKEW_OVF_EN
    logic drop_s;
    logic ovf_r;

    // A tagged word is dropped only when its FIFO is full and no pop frees a slot.
    always_comb begin
        drop_s = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            if (tag_s[i] & full_s[i] & ~pop_s) begin
                drop_s = 1'b1;
            end else begin
                drop_s = drop_s;
            end
        end
    end

    // Sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign o_overflow = ovf_r;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_out_sa_row_deskew.sv
// Directed self-checking bench for out_sa_row_deskew (ROW=8, W_DATA=8, DEPTH=8).
module tb_out_sa_row_deskew;
    logic        i_clk;
    logic        i_rst;
    logic [71:0] i_data;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_level;
    logic        o_overflow;

    int total;
    int bad;

`ifdef OUT_SA_DESKEW_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    out_sa_row_deskew #(.ROW(8), .W_DATA(8), .DEPTH(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_level   (o_level),
        .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] lane_val(int k, int i);
        return 8'(k * 8 + i);
    endfunction

    function automatic logic [63:0] vec(int k);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < 8; i++) v[8*(8-i)-1 -: 8] = lane_val(k, i);
        return v;
    endfunction

    task automatic set_lane(int i, logic tag, logic [7:0] d);
        i_data[9*(8-i)-1 -: 9] = {tag, d};
    endtask

    task automatic drive_vec(int k);
        for (int i = 0; i < 8; i++) set_lane(i, 1'b1, lane_val(k, i));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_data = 72'h0;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_ready = 1'b1;
        drive_vec(1);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
            total++; if (o_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", o_data); end
            total++; if (o_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", o_level); end
            total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
        end
        i_rst = 1'b0;
        i_ready = 1'b0;
        tick();
        total++; if (o_level !== 4'd1) begin bad++; $display("FAIL post_reset_level got=%0d exp=1", o_level); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", o_valid); end
        total++; if (o_data !== vec(1)) begin bad++; $display("FAIL post_reset_data got=%h exp=%h", o_data, vec(1)); end
        do_reset();
    endtask

    task automatic test_skew();
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_data = 72'h0;
            set_lane(c, 1'b1, 8'(8'h10 + c));
            tick();
            if (c < 7) begin
                total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_early_valid c=%0d got=%b exp=0", c, o_valid); end
            end
            total++; if (o_level !== 4'd1) begin bad++; $display("FAIL skew_level c=%0d got=%0d exp=1", c, o_level); end
        end
        i_data = 72'h0;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL skew_valid got=%b exp=1", o_valid); end
        total++; if (o_data !== 64'h1011121314151617) begin bad++; $display("FAIL skew_data got=%h exp=1011121314151617", o_data); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_one_cycle got=%b exp=0", o_valid); end
        total++; if (o_level !== 4'd0) begin bad++; $display("FAIL skew_level_end got=%0d exp=0", o_level); end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        for (int k = 3; k < 6; k++) begin
            drive_vec(k);
            tick();
        end
        i_data = 72'h0;
        tick();
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", o_valid); end
        total++; if (o_data !== vec(3)) begin bad++; $display("FAIL bp_hold got=%h exp=%h", o_data, vec(3)); end
        total++; if (o_level !== 4'd3) begin bad++; $display("FAIL bp_level got=%0d exp=3", o_level); end
        i_ready = 1'b1;
        for (int k = 3; k < 6; k++) begin
            total++; if (o_data !== vec(k)) begin bad++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, o_data, vec(k)); end
            tick();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_full_pop();
        i_ready = 1'b0;
        for (int k = 10; k < 18; k++) begin
            drive_vec(k);
            tick();
        end
        total++; if (o_level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", o_level); end
        i_ready = 1'b1;
        drive_vec(18);
        tick();
        total++; if (o_level !== 4'd8) begin bad++; $display("FAIL fullpop_level got=%0d exp=8", o_level); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", o_overflow); end
        i_data = 72'h0;
        for (int k = 11; k < 19; k++) begin
            total++; if (o_data !== vec(k)) begin bad++; $display("FAIL fullpop_drain k=%0d got=%h exp=%h", k, o_data, vec(k)); end
            tick();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_overflow();
        i_ready = 1'b0;
        for (int k = 20; k < 28; k++) begin
            drive_vec(k);
            tick();
        end
        i_data = 72'h0;
        set_lane(3, 1'b1, 8'hAA);
        tick();
        i_data = 72'h0;
        total++; if (o_overflow !== OVF_EXP) begin bad++; $display("FAIL ovf_set got=%b exp=%b", o_overflow, OVF_EXP); end
        total++; if (o_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", o_level); end
        tick();
        total++; if (o_overflow !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", o_overflow, OVF_EXP); end
        i_ready = 1'b1;
        for (int k = 20; k < 28; k++) begin
            total++; if (o_data !== vec(k)) begin bad++; $display("FAIL ovf_drain k=%0d got=%h exp=%h", k, o_data, vec(k)); end
            tick();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", o_valid); end
        total++; if (o_overflow !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky2 got=%b exp=%b", o_overflow, OVF_EXP); end
        do_reset();
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", o_overflow); end
    endtask

    task automatic test_wrap();
        logic [63:0] q[$];
        int k;
        int got;
        k = 0;
        got = 0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            i_ready = 1'($urandom_range(0, 1));
            if (q.size() > 0 && i_ready) begin
                total++; if (o_data !== q[0]) begin bad++; $display("FAIL wrap_data n=%0d got=%h exp=%h", got, o_data, q[0]); end
                void'(q.pop_front());
                got++;
            end
            if (k < 20 && q.size() < 8) begin
                drive_vec(k + 30);
                q.push_back(vec(k + 30));
                k++;
            end else begin
                i_data = 72'h0;
            end
            tick();
            total++; if (o_level !== 4'(q.size())) begin bad++; $display("FAIL wrap_level got=%0d exp=%0d", o_level, q.size()); end
            total++; if (o_valid !== (q.size() > 0)) begin bad++; $display("FAIL wrap_valid got=%b exp=%b", o_valid, q.size() > 0); end
        end
        i_data = 72'h0;
        total++; if (got != 20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", got); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        i_rst = 1'b1;
        i_ready = 1'b0;
        i_data = 72'h0;
        test_reset();
        test_skew();
        test_backpressure();
        test_full_pop();
        test_overflow();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
